// File: rtl/tt_pkg.sv
// Shared types and sizing for the truth-table extractor.
package tt_pkg;

  localparam int unsigned N_INPUTS = 4;
  localparam int unsigned N_ROWS   = 16;
  localparam int unsigned CNT_W    = 5;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    FINISH
  } state_e;

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter that times how long each input row is held before sampling.
// expired_o is high on the final settle cycle after a load.
module settle_timer #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  output logic expired_o
);

  localparam int unsigned W = $clog2(SETTLE_CYCLES + 1);

  logic [W-1:0] cnt_q, cnt_d;
  logic         expired_q, expired_d;

  // Count from SETTLE_CYCLES-1 down to zero and hold there.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = W'(SETTLE_CYCLES - 1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
    expired_d = (cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      expired_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      expired_q <= expired_d;
    end
  end

  assign expired_o = expired_q;

endmodule

// File: rtl/truth_table_extractor.sv
// Sweeps a 4-input function through all 16 rows, samples s_in per row and
// reports truth table, maxterm mask and term counts.
module truth_table_extractor
  import tt_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic                s_in,
  output logic                a,
  output logic                b,
  output logic                c,
  output logic                d,
  output logic                busy,
  output logic                done,
  output logic                result_valid,
  output logic [N_ROWS-1:0]   truth_table,
  output logic [N_ROWS-1:0]   maxterm_mask,
  output logic [CNT_W-1:0]    minterm_count,
  output logic [CNT_W-1:0]    maxterm_count,
  output logic                is_const
);

  localparam int unsigned ROW_W = N_INPUTS;

  state_e              state_q, state_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [N_INPUTS-1:0] abcd_q, abcd_d;
  logic [N_ROWS-1:0]   tt_q, tt_d, mask_q, mask_d;
  logic [CNT_W-1:0]    minc_q, minc_d, maxc_q, maxc_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic                rv_q, rv_d, const_q, const_d;
  logic                timer_load, expired;

  settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (timer_load),
    .expired_o(expired)
  );

  // Sweep sequencing; abort takes priority over start and over sampling.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    abcd_d  = abcd_q;
    tt_d    = tt_q;
    minc_d  = minc_q;
    rv_d    = rv_q;

    case (state_q)
      IDLE: begin
        if (abort) begin
          rv_d = 1'b0;
        end else if (start) begin
          state_d = DRIVE;
          row_d   = '0;
          tt_d    = '0;
          minc_d  = '0;
          rv_d    = 1'b0;
        end
      end
      DRIVE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (expired) begin
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          tt_d[row_q] = s_in;
          minc_d      = minc_q + CNT_W'(s_in);
          if (row_q == ROW_W'(N_ROWS - 1)) begin
            state_d = FINISH;
            rv_d    = 1'b1;
          end else begin
            row_d   = row_q + ROW_W'(1);
            state_d = DRIVE;
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_d == DRIVE) begin
      abcd_d = row_d;
    end

    timer_load = (state_d == DRIVE) && (state_q != DRIVE);
    busy_d     = (state_d == DRIVE) || (state_d == SAMPLE);
    done_d     = (state_d == FINISH);
    mask_d     = ~tt_d;
    maxc_d     = CNT_W'(N_ROWS) - minc_d;
    const_d    = rv_d && ((minc_d == '0) || (minc_d == CNT_W'(N_ROWS)));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      row_q   <= '0;
      abcd_q  <= '0;
      tt_q    <= '0;
      mask_q  <= '1;
      minc_q  <= '0;
      maxc_q  <= CNT_W'(N_ROWS);
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rv_q    <= 1'b0;
      const_q <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      abcd_q  <= abcd_d;
      tt_q    <= tt_d;
      mask_q  <= mask_d;
      minc_q  <= minc_d;
      maxc_q  <= maxc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rv_q    <= rv_d;
      const_q <= const_d;
    end
  end

  assign {a, b, c, d}   = abcd_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign result_valid   = rv_q;
  assign truth_table    = tt_q;
  assign maxterm_mask   = mask_q;
  assign minterm_count  = minc_q;
  assign maxterm_count  = maxc_q;
  assign is_const       = const_q;

endmodule

// File: tb/tb_truth_table_extractor.sv
// Scoreboard bench for truth_table_extractor: two instances (settle 1 and 3),
// expected results queued at start and checked when done pulses.
module tb_truth_table_extractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pass_cnt = 0;
  int total    = 0;

  logic        rst_n;
  logic        start1, abort1, s_in1, a1, b1, c1, d1, busy1, done1, rv1, const1;
  logic [15:0] tt1, mask1;
  logic [4:0]  minc1, maxc1;
  logic        start3, abort3, s_in3, a3, b3, c3, d3, busy3, done3, rv3, const3;
  logic [15:0] tt3, mask3;
  logic [4:0]  minc3, maxc3;

  logic [15:0] fn_tt;
  logic [1:0]  mode1;
  logic [3:0]  row1;

  assign row1 = {a1, b1, c1, d1};

  // Function under test for the settle-1 instance, selectable per test.
  always_comb begin
    case (mode1)
      2'd0:    s_in1 = fn_tt[row1];
      2'd1:    s_in1 = 1'b0;
      default: s_in1 = 1'b1;
    endcase
  end

  assign s_in3 = a3 & ~b3 & ~c3 & d3;

  truth_table_extractor #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .s_in(s_in1),
    .a(a1), .b(b1), .c(c1), .d(d1), .busy(busy1), .done(done1),
    .result_valid(rv1), .truth_table(tt1), .maxterm_mask(mask1),
    .minterm_count(minc1), .maxterm_count(maxc1), .is_const(const1)
  );

  truth_table_extractor #(.SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3), .s_in(s_in3),
    .a(a3), .b(b3), .c(c3), .d(d3), .busy(busy3), .done(done3),
    .result_valid(rv3), .truth_table(tt3), .maxterm_mask(mask3),
    .minterm_count(minc3), .maxterm_count(maxc3), .is_const(const3)
  );

  typedef struct {
    logic [15:0] tt;
    logic [15:0] mask;
    logic [4:0]  minc;
    logic [4:0]  maxc;
    logic        cnst;
    int          lat;
    int          t0;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  function automatic exp_t mk(input logic [15:0] tt, input logic [15:0] mask,
                              input logic [4:0] minc, input logic [4:0] maxc,
                              input logic cnst, input int lat);
    exp_t e;
    e.tt = tt; e.mask = mask; e.minc = minc; e.maxc = maxc;
    e.cnst = cnst; e.lat = lat; e.t0 = 0;
    return e;
  endfunction

  // Monitor for the settle-1 instance.
  always @(negedge clk) begin
    if (done1) begin
      if (q1.size() == 0) begin
        total++;
        $display("FAIL dut1_spurious_done: done=1 with no sweep outstanding");
      end else begin
        exp_t e;
        e = q1.pop_front();
        chk("dut1_tt",      tt1,   e.tt);
        chk("dut1_mask",    mask1, e.mask);
        chk("dut1_minc",    minc1, e.minc);
        chk("dut1_maxc",    maxc1, e.maxc);
        chk("dut1_const",   const1, e.cnst);
        chk("dut1_rv",      rv1,   1);
        chk("dut1_busy",    busy1, 0);
        chk("dut1_latency", cyc - e.t0, e.lat);
      end
    end
  end

  // Monitor for the settle-3 instance.
  always @(negedge clk) begin
    if (done3) begin
      if (q3.size() == 0) begin
        total++;
        $display("FAIL dut3_spurious_done: done=1 with no sweep outstanding");
      end else begin
        exp_t e;
        e = q3.pop_front();
        chk("dut3_tt",      tt3,   e.tt);
        chk("dut3_mask",    mask3, e.mask);
        chk("dut3_minc",    minc3, e.minc);
        chk("dut3_maxc",    maxc3, e.maxc);
        chk("dut3_const",   const3, e.cnst);
        chk("dut3_latency", cyc - e.t0, e.lat);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue1(input exp_t e);
    exp_t x;
    x = e;
    x.t0 = cyc;
    q1.push_back(x);
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
  endtask

  task automatic wait_done1(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (done1) seen = 1'b1;
    end
    if (!seen) begin
      total++;
      $display("FAIL dut1_done_timeout: no done within %0d cycles", budget);
    end
  endtask

  task automatic check_rst(input string tag);
    chk({tag, "_abcd"},  {a1, b1, c1, d1}, 0);
    chk({tag, "_busy"},  busy1,  0);
    chk({tag, "_done"},  done1,  0);
    chk({tag, "_rv"},    rv1,    0);
    chk({tag, "_tt"},    tt1,    16'h0000);
    chk({tag, "_mask"},  mask1,  16'hFFFF);
    chk({tag, "_minc"},  minc1,  0);
    chk({tag, "_maxc"},  maxc1,  16);
    chk({tag, "_const"}, const1, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int c0;
    int errs;
    rst_n  = 1'b0;
    start1 = 1'b0; abort1 = 1'b0;
    start3 = 1'b0; abort3 = 1'b0;
    mode1  = 2'd0;
    fn_tt  = 16'hAC3C;
    repeat (3) tick();
    check_rst("por");
    rst_n = 1'b1;
    tick();

    // Mixed function, zeros at rows 0,1,6,7,8,9,12,14.
    mode1 = 2'd0;
    issue1(mk(16'hAC3C, 16'h53C3, 5'd8, 5'd8, 1'b0, 33));
    wait_done1(100);
    tick();

    // Constant 0 then constant 1.
    mode1 = 2'd1;
    issue1(mk(16'h0000, 16'hFFFF, 5'd0, 5'd16, 1'b1, 33));
    wait_done1(100);
    tick();
    mode1 = 2'd2;
    issue1(mk(16'hFFFF, 16'h0000, 5'd16, 5'd0, 1'b1, 33));
    wait_done1(100);
    tick();
    chk("done_one_cycle", done1, 0);
    chk("rv_held",        rv1,   1);
    chk("const_held",     const1, 1);

    // Extra starts mid-sweep and one coinciding with FINISH are ignored.
    mode1 = 2'd0;
    c0 = cyc;
    issue1(mk(16'hAC3C, 16'h53C3, 5'd8, 5'd8, 1'b0, 33));
    while (cyc < c0 + 33) begin
      start1 = (cyc == c0 + 5) || (cyc == c0 + 17);
      tick();
    end
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk("start_in_finish_ignored", busy1, 0);
    issue1(mk(16'hAC3C, 16'h53C3, 5'd8, 5'd8, 1'b0, 33));
    wait_done1(100);
    tick();

    // start with abort in IDLE: nothing starts, result_valid cleared.
    start1 = 1'b1; abort1 = 1'b1;
    tick();
    start1 = 1'b0; abort1 = 1'b0;
    chk("start_abort_idle_busy", busy1, 0);
    chk("start_abort_idle_rv",   rv1,   0);

    // Abort during row 6 DRIVE after rows 0..5 sampled as 1.
    mode1 = 2'd2;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int i = 0; i < 100 && row1 != 4'd6; i++) tick();
    chk("abort_reached_row6", row1, 6);
    abort1 = 1'b1;
    tick();
    abort1 = 1'b0;
    chk("abort_busy",  busy1,  0);
    chk("abort_rv",    rv1,    0);
    chk("abort_tt",    tt1,    16'h003F);
    chk("abort_const", const1, 0);
    repeat (40) tick();
    chk("abort_stays_idle", busy1, 0);

    // Reset mid-sweep, then a full sweep.
    mode1 = 2'd0;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    repeat (10) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_rst("midrst");
    issue1(mk(16'hAC3C, 16'h53C3, 5'd8, 5'd8, 1'b0, 33));
    wait_done1(100);
    tick();

    // Row ordering on the settle-3 instance: each row held 4 cycles.
    c0 = cyc;
    begin
      exp_t e;
      e = mk(16'h0200, 16'hFDFF, 5'd1, 5'd15, 1'b0, 65);
      e.t0 = c0;
      q3.push_back(e);
    end
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    errs = 0;
    for (int k = 0; k < 64; k++) begin
      if ({a3, b3, c3, d3} !== 4'(k / 4)) errs++;
      tick();
    end
    chk("dut3_row_sequence", errs, 0);
    chk("dut3_done_at_65", done3, 1);
    repeat (3) tick();

    chk("q1_drained", q1.size(), 0);
    chk("q3_drained", q3.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
